// File: rtl/menu_pkg.sv
// menu_pkg: shared constants, fetch FSM state type and RAM address helper for
// the menu text overlay renderer.
//   COLS/ROWS         : character grid (32x28 cells, 256x224 pixels)
//   TEXT_BASE         : byte address of cell (0,0)
//   FONT_BASE         : byte address of glyph 0, row 0 (8 bytes per glyph)
//   MENU_AW/MENU_DW   : RAM port-B address / data widths
package menu_pkg;

   localparam int unsigned COLS    = 32;
   localparam int unsigned ROWS    = 28;
   localparam int unsigned MENU_AW = 11;
   localparam int unsigned MENU_DW = 8;
   localparam int unsigned LINES   = ROWS * 8;
   localparam int unsigned PIXELS  = COLS * 8;

   localparam logic [MENU_AW-1:0] TEXT_BASE = 11'h000;
   localparam logic [MENU_AW-1:0] FONT_BASE = 11'h400;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_CHAR,
      FS_CODE,
      FS_GLYPH,
      FS_FULL
   } fetch_state_t;

   // glyph_sel=0: text cell address for (col, line fy).
   // glyph_sel=1: font row address for 7-bit code on line fy.
   function automatic logic [MENU_AW-1:0] menu_addr(
      input logic       glyph_sel,
      input logic [6:0] code,
      input logic [4:0] col,
      input logic [7:0] fy
   );
      logic [MENU_AW-1:0] row_idx;
      row_idx = MENU_AW'(fy[7:3]);
      if (glyph_sel)
         return FONT_BASE + {1'b0, code, fy[2:0]};
      return TEXT_BASE + row_idx * MENU_AW'(COLS) + MENU_AW'(col);
   endfunction

endpackage

// File: rtl/menu_cell_fetch.sv
// menu_cell_fetch: walks the text grid in raster order, fetching a character
// code then the matching glyph row for every cell of every scanline, and holds
// the result in a one-entry prefetch register.
//   clk, reset      : clock, synchronous active-high reset
//   frame_start     : restart fetching at cell (0,0), flushing the prefetch
//   take            : shifter consumes the prefetch entry this cycle
//   mem_ce/mem_addr : RAM port-B read enable / address
//   mem_dout        : RAM port-B data, one cycle after the sampling edge
//   pf_valid/pf_glyph/pf_inv : prefetch entry (glyph row, invert flag)
module menu_cell_fetch
   import menu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               take,
   output logic               mem_ce,
   output logic [MENU_AW-1:0] mem_addr,
   input  logic [MENU_DW-1:0] mem_dout,
   output logic               pf_valid,
   output logic [MENU_DW-1:0] pf_glyph,
   output logic               pf_inv
);

   fetch_state_t state, state_nxt;
   logic [4:0]   col;
   logic [7:0]   fy;
   logic         code_inv;
   logic         last_cell;

   assign last_cell = (col == 5'(COLS - 1)) && (fy == 8'(LINES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= FS_IDLE;
      else       state <= state_nxt;
   end

   // The glyph address in CODE is formed straight from mem_dout so that the
   // font read is issued in the cycle the code arrives; this keeps the cell
   // cost at 4 cycles (CHAR, CODE, GLYPH, FULL).
   always_comb begin
      state_nxt = state;
      mem_ce    = 1'b0;
      mem_addr  = '0;
      unique case (state)
         FS_IDLE: ;
         FS_CHAR: begin
            mem_ce    = 1'b1;
            mem_addr  = menu_addr(1'b0, 7'd0, col, fy);
            state_nxt = FS_CODE;
         end
         FS_CODE: begin
            mem_ce    = 1'b1;
            mem_addr  = menu_addr(1'b1, mem_dout[6:0], col, fy);
            state_nxt = FS_GLYPH;
         end
         FS_GLYPH: state_nxt = FS_FULL;
         FS_FULL: begin
            if (take) state_nxt = last_cell ? FS_IDLE : FS_CHAR;
         end
         default: state_nxt = FS_IDLE;
      endcase
      if (frame_start) state_nxt = FS_CHAR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col      <= '0;
         fy       <= '0;
         code_inv <= 1'b0;
         pf_valid <= 1'b0;
         pf_glyph <= '0;
         pf_inv   <= 1'b0;
      end else if (frame_start) begin
         col      <= '0;
         fy       <= '0;
         pf_valid <= 1'b0;
      end else begin
         unique case (state)
            FS_CODE: code_inv <= mem_dout[7];
            FS_GLYPH: begin
               pf_glyph <= mem_dout;
               pf_inv   <= code_inv;
               pf_valid <= 1'b1;
            end
            FS_FULL: begin
               if (take) begin
                  pf_valid <= 1'b0;
                  if (col == 5'(COLS - 1)) begin
                     col <= '0;
                     fy  <= fy + 8'd1;
                  end else begin
                     col <= col + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/menu_text_renderer.sv
// menu_text_renderer: renders the 32x28 text menu as a 256x224 1-bit overlay
// stream from port B of the menu RAM.
//   clk, reset      : clock, synchronous active-high reset
//   frame_start     : one-cycle pulse, (re)starts rendering at pixel (0,0)
//   mem_ce/mem_addr : RAM port-B read enable / address
//   mem_dout        : RAM port-B read data
//   out_valid/out_ready : pixel handshake to the video mixer
//   out_pixel       : 1 = foreground
//   out_x/out_y     : pixel column / line
//   out_last        : high with pixel (255,223)
module menu_text_renderer
   import menu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   output logic               mem_ce,
   output logic [MENU_AW-1:0] mem_addr,
   input  logic [MENU_DW-1:0] mem_dout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_pixel,
   output logic [7:0]         out_x,
   output logic [7:0]         out_y,
   output logic               out_last
);

   logic               pf_valid;
   logic [MENU_DW-1:0] pf_glyph;
   logic               pf_inv;
   logic               take;
   logic               handshake;
   logic               cell_end;
   logic [MENU_DW-1:0] sh_glyph;
   logic               sh_inv;
   logic               sh_valid;

   menu_cell_fetch u_fetch (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .take        (take),
      .mem_ce      (mem_ce),
      .mem_addr    (mem_addr),
      .mem_dout    (mem_dout),
      .pf_valid    (pf_valid),
      .pf_glyph    (pf_glyph),
      .pf_inv      (pf_inv)
   );

   assign handshake = sh_valid & out_ready;
   assign cell_end  = handshake & (out_x[2:0] == 3'd7);
   // An abort must not load the prefetch of the frame being discarded.
   assign take      = pf_valid & ~frame_start & (~sh_valid | cell_end);

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_valid <= 1'b0;
         sh_glyph <= '0;
         sh_inv   <= 1'b0;
         out_x    <= '0;
         out_y    <= '0;
      end else if (frame_start) begin
         sh_valid <= 1'b0;
         out_x    <= '0;
         out_y    <= '0;
      end else begin
         if (handshake) begin
            out_x <= out_x + 8'd1;
            if (out_x == 8'(PIXELS - 1))
               out_y <= (out_y == 8'(LINES - 1)) ? '0 : out_y + 8'd1;
         end
         if (take) begin
            sh_glyph <= pf_glyph;
            sh_inv   <= pf_inv;
            sh_valid <= 1'b1;
         end else if (cell_end) begin
            sh_valid <= 1'b0;
         end
      end
   end

   assign out_valid = sh_valid;
   assign out_pixel = sh_glyph[out_x[2:0]] ^ sh_inv;
   assign out_last  = sh_valid & (out_x == 8'(PIXELS - 1)) & (out_y == 8'(LINES - 1));

endmodule
